cond_unit: RTL and testbench



---
 rtl/cond_unit_pkg.sv | 27 ++
 rtl/cond_unit_if.sv | 25 ++
 rtl/cond_unit_check.sv | 36 +++
 rtl/cond_unit.sv | 43 ++++
 tb/tb_cond_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: condition codes and flag bit positions shared by the condition unit.
package cond_pkg;
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder/ALU-facing signals of the condition unit.
interface cond_unit_if;
  logic [3:0] ALUFlags;
  logic [3:0] Cond;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       InstrValid;
  logic       Stall;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       CondExReg;
  modport master (
    output ALUFlags, Cond, FlagW, PCS, RegW, MemW, InstrValid, Stall,
    input  PCSrc, RegWrite, MemWrite, Flags, CondEx, CondExReg
  );
  modport slave (
    input  ALUFlags, Cond, FlagW, PCS, RegW, MemW, InstrValid, Stall,
    output PCSrc, RegWrite, MemWrite, Flags, CondEx, CondExReg
  );
endinterface

// File: rtl/cond_unit_check.sv
// cond_check: combinational decode of the 4-bit condition field against stored flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);
  logic w_n, w_z, w_c, w_v, w_ge;
  assign w_n  = i_flags[FLAG_N];
  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  assign w_ge = (w_n == w_v);
  always_comb begin
    o_cond_ex = 1'b1;
    unique case (cond_e'(i_cond))
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      COND_NV: o_cond_ex = 1'b1;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: architectural NZCV register, condition evaluation and write-strobe gating.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input logic        clk,
  input logic        reset,
  cond_unit_if.slave bus
);
  logic [3:0] r_flags;
  logic       r_cond_ex;
  logic       w_cond_ex;
  logic       w_go;
  cond_check u_check (
    .i_cond    (bus.Cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );
  assign w_go = w_cond_ex & bus.InstrValid & ~bus.Stall & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags   <= RESET_FLAGS;
      r_cond_ex <= 1'b0;
    end else begin
      if (w_go && bus.FlagW[FLAGW_NZ]) begin
        r_flags[FLAG_N] <= bus.ALUFlags[FLAG_N];
        r_flags[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (w_go && bus.FlagW[FLAGW_CV]) begin
        r_flags[FLAG_C] <= bus.ALUFlags[FLAG_C];
        r_flags[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
      if (!bus.Stall) r_cond_ex <= w_cond_ex & bus.InstrValid;
    end
  end
  assign bus.PCSrc     = bus.PCS  & w_go;
  assign bus.RegWrite  = bus.RegW & w_go;
  assign bus.MemWrite  = bus.MemW & w_go;
  assign bus.Flags     = r_flags;
  assign bus.CondEx    = w_cond_ex;
  assign bus.CondExReg = r_cond_ex;
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed self-checking bench for cond_unit.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  cond_unit_if bus ();
  cond_unit #(.RESET_FLAGS(4'b0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, {1'b0, bus.PCSrc, bus.RegWrite, bus.MemWrite}, {1'b0, exp});
  endtask

  task automatic load(input logic [3:0] f);
    bus.Cond = 4'b1110; bus.InstrValid = 1'b1; bus.Stall = 1'b0;
    bus.FlagW = 2'b11; bus.ALUFlags = f;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
    tick();
    bus.FlagW = 2'b00;
    chk("load", bus.Flags, f);
  endtask

  function automatic logic expect_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cc, v, x;
    logic [15:0] t;
    n = f[0]; z = f[1]; cc = f[2]; v = f[3]; x = n ^ v;
    t = {1'b1, 1'b1, z | x, ~z & ~x, x, ~x, ~cc | z, cc & ~z,
         ~v, v, ~n, n, ~cc, cc, ~z, z};
    return t[c];
  endfunction

  logic [3:0] pre [7] = '{4'b0000, 4'b0010, 4'b0100, 4'b1001, 4'b0001, 4'b1010, 4'b0011};

  initial begin
    reset = 1'b1;
    bus.ALUFlags = 4'b1111; bus.Cond = 4'b1110; bus.FlagW = 2'b11;
    bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1;
    bus.InstrValid = 1'b1; bus.Stall = 1'b0;
    strobes("reset_strobes", 3'b000);
    tick();
    strobes("reset_strobes2", 3'b000);
    tick();
    chk("reset_flags", bus.Flags, 4'b0000);
    chk("reset_cexreg", {3'b0, bus.CondExReg}, 4'b0000);
    reset = 1'b0; bus.FlagW = 2'b00; bus.Cond = 4'b0000;
    #1;
    chk("post_reset_eq", {3'b0, bus.CondEx}, 4'b0000);
    strobes("post_reset_strobes", 3'b000);

    load(4'b0000);
    bus.ALUFlags = 4'b1111; bus.FlagW = 2'b10;
    tick();
    chk("group_nz", bus.Flags, 4'b0011);
    bus.FlagW = 2'b01;
    tick();
    chk("group_cv", bus.Flags, 4'b1111);

    foreach (pre[k]) begin
      load(pre[k]);
      bus.RegW = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bus.Cond = c[3:0];
        #1;
        chk($sformatf("sweep_f%b_c%0d", pre[k], c), {3'b0, bus.CondEx}, {3'b0, expect_cond(pre[k], c[3:0])});
        chk($sformatf("sweep_rw_f%b_c%0d", pre[k], c), {3'b0, bus.RegWrite}, {3'b0, expect_cond(pre[k], c[3:0])});
      end
    end

    load(4'b1001); bus.Cond = 4'b1010; #1;
    chk("spot_ge", {3'b0, bus.CondEx}, 4'b0001);
    load(4'b0001); bus.Cond = 4'b1011; #1;
    chk("spot_lt", {3'b0, bus.CondEx}, 4'b0001);
    load(4'b0100); bus.Cond = 4'b1000; #1;
    chk("spot_hi", {3'b0, bus.CondEx}, 4'b0001);
    load(4'b0110); bus.Cond = 4'b1001; #1;
    chk("spot_ls", {3'b0, bus.CondEx}, 4'b0001);
    bus.Cond = 4'b1000; #1;
    chk("spot_hi_z", {3'b0, bus.CondEx}, 4'b0000);

    load(4'b0000);
    bus.Cond = 4'b0000; bus.RegW = 1'b1; bus.MemW = 1'b1;
    bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    strobes("failed_strobes", 3'b000);
    tick();
    chk("failed_flags", bus.Flags, 4'b0000);
    chk("failed_cexreg", {3'b0, bus.CondExReg}, 4'b0000);

    load(4'b0000);
    bus.Cond = 4'b1110; bus.FlagW = 2'b10; bus.ALUFlags = 4'b0010; bus.RegW = 1'b0; bus.MemW = 1'b0;
    #1;
    chk("b2b_old_flags", bus.Flags, 4'b0000);
    tick();
    bus.Cond = 4'b0000; bus.FlagW = 2'b00; bus.RegW = 1'b1;
    #1;
    chk("b2b_condex", {3'b0, bus.CondEx}, 4'b0001);
    chk("b2b_regwrite", {3'b0, bus.RegWrite}, 4'b0001);
    chk("b2b_cexreg", {3'b0, bus.CondExReg}, 4'b0001);

    load(4'b0000);
    bus.Cond = 4'b0000; bus.FlagW = 2'b10; bus.ALUFlags = 4'b0010; bus.RegW = 1'b0;
    #1;
    chk("same_cycle_pre", {3'b0, bus.CondEx}, 4'b0000);
    tick();
    chk("same_cycle_nowrite", bus.Flags, 4'b0000);

    bus.Cond = 4'b1110; bus.InstrValid = 1'b0; bus.FlagW = 2'b11; bus.ALUFlags = 4'b1111;
    bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1;
    strobes("invalid_strobes", 3'b000);
    tick();
    chk("invalid_flags", bus.Flags, 4'b0000);
    chk("invalid_cexreg", {3'b0, bus.CondExReg}, 4'b0000);

    bus.InstrValid = 1'b1; bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobes($sformatf("stall_strobes%0d", i), 3'b000);
      tick();
      chk($sformatf("stall_flags%0d", i), bus.Flags, 4'b0000);
      chk($sformatf("stall_cexreg%0d", i), {3'b0, bus.CondExReg}, 4'b0000);
    end
    bus.Stall = 1'b0;
    strobes("unstall_strobes", 3'b111);
    tick();
    chk("unstall_flags", bus.Flags, 4'b1111);
    chk("unstall_cexreg", {3'b0, bus.CondExReg}, 4'b0001);

    reset = 1'b1; bus.ALUFlags = 4'b1010;
    strobes("reset_wins_strobes", 3'b000);
    tick();
    chk("reset_wins_flags", bus.Flags, 4'b0000);
    chk("reset_wins_cexreg", {3'b0, bus.CondExReg}, 4'b0000);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
